jk_bank_ctrl: RTL and testbench

- Arbitrates two command requesters sharing one bank of WIDTH JK flip-flops and sequences J/K drive per bit.
- Commands use JK semantics (hold/clear/set/toggle) on masked bits. With no command pending, the bank can free-run as a synchronous binary counter built from JK toggle terms.
- Sits between control logic and the JK register bank.

---
 rtl/jk_bank_ctrl.sv | 128 ++++++++++++
 tb/tb_jk_bank_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// Two-requester arbiter and J/K sequencer for a WIDTH-bit JK flip-flop bank, with free-running binary count.
// Optional macro JK_BANK_DOWN_EN adds the cnt_dn input for down-counting.
module jk_bank_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  output logic             req1_ready,
  input  logic             cnt_en,
`ifdef JK_BANK_DOWN_EN
  input  logic             cnt_dn,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             busy,
  output logic             grant_id,
  output logic             wrap
);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t           state, state_next;
  logic             last_grant;
  logic             accept0, accept1, count, dn, wrap_next;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r, j, k, tog, q_next;

`ifdef JK_BANK_DOWN_EN
  assign dn = cnt_dn;
`else
  assign dn = 1'b0;
`endif

  // Round-robin: on a tie, the requester that did not win last time is served.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant;
        req1_ready = !last_grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign accept0 = req0_valid & req0_ready;
  assign accept1 = req1_valid & req1_ready;
  assign count   = (state == IDLE) && cnt_en && !accept0 && !accept1;

  // Ripple toggle terms: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    tog    = '0;
    tog[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tog[i] = tog[i-1] & (dn ? ~q[i-1] : q[i-1]);
    end
  end

  always_comb begin
    state_next = state;
    j          = '0;
    k          = '0;
    if (state == APPLY) begin
      // op encoding maps directly onto {J,K}.
      for (int i = 0; i < WIDTH; i++) begin
        if (mask_r[i]) begin
          j[i] = op_r[1];
          k[i] = op_r[0];
        end
      end
      state_next = IDLE;
    end else if (accept0 || accept1) begin
      state_next = APPLY;
    end else if (count) begin
      j = tog;
      k = tog;
    end
  end

  assign q_next    = (j & ~q) | (~k & q);
  assign wrap_next = count && (dn ? (q == '0) : (&q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      q          <= '0;
      wrap       <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      wrap  <= wrap_next;
      if (accept0) begin
        last_grant <= 1'b0;
        grant_id   <= 1'b0;
      end else if (accept1) begin
        last_grant <= 1'b1;
        grant_id   <= 1'b1;
      end
    end
  end

  // Latched command needs no reset: it is only consumed in APPLY.
  always_ff @(posedge clk) begin
    if (accept0) begin
      op_r   <= req0_op;
      mask_r <= req0_mask;
    end else if (accept1) begin
      op_r   <= req1_op;
      mask_r <= req1_mask;
    end
  end

  assign q_bar = ~q;
  assign busy  = (state == APPLY);

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Randomized and directed bench for jk_bank_ctrl against a command/counter reference model.
module tb_jk_bank_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid, cnt_en, cnt_dn;
  logic [1:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_mask, req1_mask, q, q_bar;
  logic             req0_ready, req1_ready, busy, grant_id, wrap;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int   m_q;
  bit   m_apply, m_last, m_gid, m_wrap;
  int   m_op, m_mask;

  jk_bank_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_mask(req0_mask), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_mask(req1_mask), .req1_ready(req1_ready),
    .cnt_en(cnt_en),
`ifdef JK_BANK_DOWN_EN
    .cnt_dn(cnt_dn),
`endif
    .q(q), .q_bar(q_bar), .busy(busy), .grant_id(grant_id), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int apply_op(int val, int op, int mask);
    case (op)
      1:       return val & ~mask & 255;
      2:       return (val | mask) & 255;
      3:       return (val ^ mask) & 255;
      default: return val;
    endcase
  endfunction

  // One clock cycle: drive at negedge, check, then advance the model to match the next posedge.
  task automatic cyc(input bit rst, input bit v0, input int op0, input int mk0,
                     input bit v1, input int op1, input int mk1, input bit en, input bit dn);
    bit e_r0, e_r1;
    @(negedge clk);
    reset = rst; req0_valid = v0; req0_op = op0[1:0]; req0_mask = mk0[7:0];
    req1_valid = v1; req1_op = op1[1:0]; req1_mask = mk1[7:0];
    cnt_en = en; cnt_dn = dn;
    #1;
    e_r0 = 0; e_r1 = 0;
    if (!rst && !m_apply) begin
      if (v0 && v1) begin e_r0 = m_last; e_r1 = !m_last; end
      else begin e_r0 = v0; e_r1 = v1; end
    end
    check_eq("q", q, m_q);
    check_eq("q_bar", q_bar, ~m_q & 255);
    check_eq("busy", busy, m_apply);
    check_eq("grant_id", grant_id, m_gid);
    check_eq("wrap", wrap, m_wrap);
    check_eq("ready0", req0_ready, e_r0);
    check_eq("ready1", req1_ready, e_r1);
    check_eq("ready_excl", req0_ready & req1_ready, 0);
    if (rst) begin
      m_q = 0; m_apply = 0; m_last = 1; m_gid = 0; m_wrap = 0;
    end else if (m_apply) begin
      m_q = apply_op(m_q, m_op, m_mask); m_apply = 0; m_wrap = 0;
    end else if (v0 && e_r0) begin
      m_op = op0; m_mask = mk0 & 255; m_last = 0; m_gid = 0; m_apply = 1; m_wrap = 0;
    end else if (v1 && e_r1) begin
      m_op = op1; m_mask = mk1 & 255; m_last = 1; m_gid = 1; m_apply = 1; m_wrap = 0;
    end else if (en) begin
`ifdef JK_BANK_DOWN_EN
      if (dn) begin
        m_wrap = (m_q == 0); m_q = (m_q + 255) % 256;
      end else begin
        m_wrap = (m_q == 255); m_q = (m_q + 1) % 256;
      end
`else
      m_wrap = (m_q == 255); m_q = (m_q + 1) % 256;
`endif
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmd0(input int op, input int mk);
    cyc(0, 1, op, mk, 0, 0, 0, 0, 0);
    idle(1);
  endtask

  initial begin
    reset = 1; req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_mask = 0; req1_mask = 0; cnt_en = 0; cnt_dn = 0;
    m_q = 0; m_apply = 0; m_last = 1; m_gid = 0; m_wrap = 0; m_op = 0; m_mask = 0;
    @(posedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset state, then req0 set 0x0F
    cyc(0, 1, 2, 8'h0F, 0, 0, 0, 0, 0);
    idle(2);
    // Three contended rounds: grants alternate
    for (int r = 0; r < 3; r++) begin
      cyc(0, 1, 3, 8'h01, 1, 3, 8'h02, 0, 0);
      cyc(0, 1, 3, 8'h01, 1, 3, 8'h02, 0, 0);
    end
    idle(1);
    // Toggle/clear/no-op sequence from 0xAA
    cmd0(1, 8'hFF); cmd0(2, 8'hAA);
    cyc(0, 0, 0, 0, 1, 3, 8'hFF, 0, 0); idle(1);
    cyc(0, 0, 0, 0, 1, 1, 8'h0F, 0, 0); idle(1);
    cyc(0, 0, 0, 0, 1, 0, 8'hFF, 0, 0); idle(1);
    // Counter wrap from 0xFE, then mid-count set 0x80
    cmd0(1, 8'hFF); cmd0(2, 8'hFE);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 2, 8'h80, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Reset during APPLY of set 0xFF
    cyc(0, 1, 2, 8'hFF, 0, 0, 0, 0, 0);
    cyc(1, 1, 2, 8'hFF, 1, 2, 8'hFF, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
`ifdef JK_BANK_DOWN_EN
    cmd0(1, 8'hFF); cmd0(2, 8'h01);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
`endif
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
          ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
